// File: rtl/optimsoc_pkg.sv
// Shared tile-configuration types: static config_t, runtime window_t, bus FSM states and the register map.
package optimsoc;

  typedef struct packed {
    logic [15:0]       NUMTILES;
    logic [15:0]       NUMCTS;
    logic [63:0][15:0] CTLIST;
    logic [7:0]        CORES_PER_TILE;
    logic [31:0]       LMEM_SIZE;
    logic [7:0]        NOC_FLIT_WIDTH;
  } config_t;

  localparam config_t CONFIG_ZERO = '0;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
    logic        enable;
  } window_t;

  typedef enum logic {ST_IDLE, ST_RESP} bus_state_t;

  localparam logic [31:0] VERSION = 32'h0001_0000;

  localparam logic [15:0] ADR_VERSION        = 16'h0000;
  localparam logic [15:0] ADR_TILEID         = 16'h0004;
  localparam logic [15:0] ADR_NUMTILES       = 16'h0008;
  localparam logic [15:0] ADR_NUMCTS         = 16'h000C;
  localparam logic [15:0] ADR_CORES_PER_TILE = 16'h0010;
  localparam logic [15:0] ADR_LMEM_SIZE      = 16'h0014;
  localparam logic [15:0] ADR_NOC_FLIT_WIDTH = 16'h0018;
  localparam logic [15:0] ADR_N_WINDOWS      = 16'h001C;
  localparam logic [15:0] ADR_CTLIST         = 16'h0100;
  localparam logic [15:0] ADR_WIN            = 16'h0200;
  localparam logic [15:0] ADR_COMMIT         = 16'h0300;
  localparam logic [15:0] ADR_STATUS         = 16'h0304;

  // Word offset within a window: 0 BASE, 1 MASK, 2 CTRL, 3 is a hole.
  function automatic logic [31:0] win_field(input window_t w, input logic [1:0] fld);
    case (fld)
      2'd0:    return w.base;
      2'd1:    return w.mask;
      2'd2:    return {31'b0, w.enable};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/tile_window_match.sv
// Combinational priority match of an address against the active windows; lowest enabled match wins.
module tile_window_match
  import optimsoc::*;
#(
  parameter int N_WINDOWS = 2
) (
  input  window_t [N_WINDOWS-1:0] windows,
  input  logic [31:0]             addr,
  output logic                    hit,
  output logic [2:0]              idx
);

  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = N_WINDOWS - 1; i >= 0; i--) begin
      if (windows[i].enable && ((addr & windows[i].mask) == (windows[i].base & windows[i].mask))) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tile_config_regs.sv
// Tile config/status registers with shadowed address windows; 1-cycle bus response and 1-cycle pipelined lookup.
// Defining OPTIMSOC_CONF_LOCK_EN adds a set-only lock (STATUS bit1) that freezes window and COMMIT writes.
module tile_config_regs
  import optimsoc::*;
#(
  parameter config_t CONFIG    = CONFIG_ZERO,
  parameter int      TILEID    = 0,
  parameter int      N_WINDOWS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        lu_valid_i,
  input  logic [31:0] lu_addr_i,
  output logic        lu_done_o,
  output logic        lu_hit_o,
  output logic [2:0]  lu_idx_o
);

  bus_state_t               state;
  window_t [N_WINDOWS-1:0]  shadow;
  window_t [N_WINDOWS-1:0]  active;
  logic                     locked;
  logic                     req_wr;
  logic [15:0]              req_adr;
  logic [31:0]              req_dat;
  logic                     dec_ok;
  logic                     dec_wr_ok;
  logic [31:0]              dec_dat;
  logic                     bus_err;
  logic                     match_hit;
  logic [2:0]               match_idx;

  always_comb begin
    dec_ok    = 1'b0;
    dec_wr_ok = 1'b0;
    dec_dat   = '0;
    case (wb_adr_i)
      ADR_VERSION:        begin dec_ok = 1'b1; dec_dat = VERSION; end
      ADR_TILEID:         begin dec_ok = 1'b1; dec_dat = 32'(TILEID); end
      ADR_NUMTILES:       begin dec_ok = 1'b1; dec_dat = {16'b0, CONFIG.NUMTILES}; end
      ADR_NUMCTS:         begin dec_ok = 1'b1; dec_dat = {16'b0, CONFIG.NUMCTS}; end
      ADR_CORES_PER_TILE: begin dec_ok = 1'b1; dec_dat = {24'b0, CONFIG.CORES_PER_TILE}; end
      ADR_LMEM_SIZE:      begin dec_ok = 1'b1; dec_dat = CONFIG.LMEM_SIZE; end
      ADR_NOC_FLIT_WIDTH: begin dec_ok = 1'b1; dec_dat = {24'b0, CONFIG.NOC_FLIT_WIDTH}; end
      ADR_N_WINDOWS:      begin dec_ok = 1'b1; dec_dat = 32'(N_WINDOWS); end
      ADR_COMMIT:         begin dec_ok = 1'b1; dec_wr_ok = !locked; end
      ADR_STATUS: begin
        dec_ok  = 1'b1;
        dec_dat = {30'b0, locked, (shadow != active)};
`ifdef OPTIMSOC_CONF_LOCK_EN
        dec_wr_ok = 1'b1;
`endif
      end
      default: begin
        if (wb_adr_i[15:8] == ADR_CTLIST[15:8] && wb_adr_i[1:0] == 2'b00) begin
          dec_ok = 1'b1;
          if ({10'b0, wb_adr_i[7:2]} < CONFIG.NUMCTS)
            dec_dat = {16'b0, CONFIG.CTLIST[wb_adr_i[7:2]]};
        end else if (wb_adr_i[15:7] == ADR_WIN[15:7] && wb_adr_i[1:0] == 2'b00 &&
                     wb_adr_i[3:2] != 2'd3) begin
          for (int i = 0; i < N_WINDOWS; i++) begin
            if (wb_adr_i[6:4] == 3'(i)) begin
              dec_ok    = 1'b1;
              dec_wr_ok = !locked;
              dec_dat   = win_field(shadow[i], wb_adr_i[3:2]);
            end
          end
        end
      end
    endcase
  end

  assign bus_err = !dec_ok || (wb_we_i && !dec_wr_ok);

  // Writes land on the edge that ends RESP, so a commit becomes visible to lookups one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      req_wr   <= 1'b0;
      req_adr  <= '0;
      req_dat  <= '0;
      shadow   <= '0;
      active   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            state    <= ST_RESP;
            wb_ack_o <= !bus_err;
            wb_err_o <= bus_err;
            wb_dat_o <= bus_err ? '0 : dec_dat;
            req_wr   <= wb_we_i && !bus_err;
            req_adr  <= wb_adr_i;
            req_dat  <= wb_dat_i;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
          req_wr   <= 1'b0;
          if (req_wr) begin
            for (int i = 0; i < N_WINDOWS; i++) begin
              if (req_adr[15:8] == ADR_WIN[15:8] && req_adr[6:4] == 3'(i)) begin
                case (req_adr[3:2])
                  2'd0:    shadow[i].base   <= req_dat;
                  2'd1:    shadow[i].mask   <= req_dat;
                  2'd2:    shadow[i].enable <= req_dat[0];
                  default: ;
                endcase
              end
            end
            if (req_adr == ADR_COMMIT && req_dat[0])
              active <= shadow;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef OPTIMSOC_CONF_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      locked <= 1'b0;
    else if (state == ST_RESP && req_wr && req_adr == ADR_STATUS && req_dat[1])
      locked <= 1'b1;
  end
`else
  assign locked = 1'b0;
`endif

  tile_window_match #(.N_WINDOWS(N_WINDOWS)) u_match (
    .windows (active),
    .addr    (lu_addr_i),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_done_o <= 1'b0;
      lu_hit_o  <= 1'b0;
      lu_idx_o  <= 3'd0;
    end else begin
      lu_done_o <= lu_valid_i;
      lu_hit_o  <= lu_valid_i && match_hit;
      lu_idx_o  <= lu_valid_i ? match_idx : 3'd0;
    end
  end

endmodule
